// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings: funct3 values, LSU FSM states and the legality check.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W_BITS = 3;

  localparam logic [F3_W_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_RD    = 3'd1,
    LSU_RWAIT = 3'd2,
    LSU_WR    = 3'd3,
    LSU_DONE  = 3'd4
  } lsu_state_e;

  // Stores only have signed widths; loads also allow the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [F3_W_BITS-1:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load sign/zero extension and sub-word store merge.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [F3_W_BITS-1:0] funct3_i,
  input  logic [XLEN-1:0]      rdata_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic [XLEN-1:0]      ld_data_c,
  output logic [XLEN-1:0]      st_data_c
);

  always_comb begin
    ld_data_c = rdata_i;
    st_data_c = wdata_i;
    case (funct3_i)
      F3_B: begin
        ld_data_c = {{24{rdata_i[7]}}, rdata_i[7:0]};
        st_data_c = {rdata_i[31:8], wdata_i[7:0]};
      end
      F3_H: begin
        ld_data_c = {{16{rdata_i[15]}}, rdata_i[15:0]};
        st_data_c = {rdata_i[31:16], wdata_i[15:0]};
      end
      F3_BU:   ld_data_c = {24'd0, rdata_i[7:0]};
      F3_HU:   ld_data_c = {16'd0, rdata_i[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a 4-byte-wide data_mem; sub-word stores use read-modify-write.
// Optional misalignment/illegal-funct3 trap reporting is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [F3_W_BITS-1:0] req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic                 mem_op,
  output logic                 mem_wr,
  input  logic [XLEN-1:0]      mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e             state_q, state_d;
  logic                   we_q, we_d;
  logic [F3_W_BITS-1:0]   f3_q, f3_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]        wbuf_q, wbuf_d;
  logic [XLEN-1:0]        rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   ready_q, valid_q, op_q, wr_q;

  logic [XLEN-1:0]        ld_data_c, st_data_c;
  logic                   misalign_c, reject_c;
  logic                   unused_addr_c;

  // Upper address bits are outside data_mem and intentionally dropped.
  assign unused_addr_c = ^req_addr[XLEN-1:ADDR_W];

  assign misalign_c = TRAP_EN &&
    ((((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)));
  assign reject_c = !f3_legal(req_we, req_funct3) || misalign_c;

  lsu_align u_align (
    .funct3_i  (f3_q),
    .rdata_i   (mem_rdata),
    .wdata_i   (wbuf_q),
    .ld_data_c (ld_data_c),
    .st_data_c (st_data_c)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[ADDR_W-1:0];
          wbuf_d  = req_wdata;
          rdata_d = '0;
          err_d   = TRAP_EN && reject_c;
          if (reject_c)                             state_d = LSU_DONE;
          else if (req_we && (req_funct3 == F3_W))  state_d = LSU_WR;
          else                                      state_d = LSU_RD;
        end
      end
      LSU_RD:    state_d = LSU_RWAIT;
      LSU_RWAIT: begin
        // mem_rdata holds the word fetched in RD; stores merge into it, loads format it.
        if (we_q) begin
          wbuf_d  = st_data_c;
          state_d = LSU_WR;
        end else begin
          rdata_d = ld_data_c;
          state_d = LSU_DONE;
        end
      end
      LSU_WR:    state_d = LSU_DONE;
      LSU_DONE:  state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  // Strobes are registered from the next state so a reset drops mem_wr before the write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      op_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= (state_d == LSU_IDLE);
      valid_q <= (state_d == LSU_DONE);
      op_q    <= (state_d == LSU_RD) || (state_d == LSU_WR);
      wr_q    <= (state_d == LSU_WR);
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wbuf_q;
  assign mem_op     = op_q;
  assign mem_wr     = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with scoreboard plus reset-abort sequences.
module tb_load_store_unit;
  import rv32i_pkg::*;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_op, mem_wr;

  int total = 0;
  int bad   = 0;
  int op_cnt = 0;
  int wr_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vt[$];

  logic [7:0] mem [MEM_BYTES];

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_op     (mem_op),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: 4-byte little-endian access at Addr..Addr+3, registered read.
  always @(posedge clk) begin
    if (mem_op) begin
      op_cnt <= op_cnt + 1;
      if (mem_wr) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++) mem[ADDR_W'(int'(mem_addr) + b)] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= {mem[ADDR_W'(int'(mem_addr) + 3)], mem[ADDR_W'(int'(mem_addr) + 2)],
                      mem[ADDR_W'(int'(mem_addr) + 1)], mem[mem_addr]};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, " rdata"}, resp_rdata, e.rdata);
        chk({e.name, " err"}, 32'(resp_err), 32'(e.err));
      end
    end
  end

  function automatic void add(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input logic ee, input int lat);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    vt.push_back(v);
  endfunction

  task automatic run_req(input vec_t v);
    int   ops0, wrs0, lat, exp_ops, exp_wrs;
    bit   seen;
    exp_t e;
    @(negedge clk);
    chk({v.name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    ops0 = op_cnt; wrs0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom()); req_funct3 = 3'($urandom());
    req_addr = $urandom(); req_wdata = $urandom();
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; lat = k; end
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    if (!seen && sb_q.size() != 0) void'(sb_q.pop_front());
    case (v.exp_lat)
      1:       begin exp_ops = 0; exp_wrs = 0; end
      2:       begin exp_ops = 1; exp_wrs = 1; end
      3:       begin exp_ops = 1; exp_wrs = 0; end
      default: begin exp_ops = 2; exp_wrs = 1; end
    endcase
    chk({v.name, " mem_ops"}, 32'(op_cnt - ops0), 32'(exp_ops));
    chk({v.name, " mem_writes"}, 32'(wr_cnt - wrs0), 32'(exp_wrs));
    @(negedge clk);
    chk({v.name, " resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic load_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.we = 1'b0; v.f3 = F3_W; v.addr = addr; v.wdata = '0;
    v.exp_rdata = exp; v.exp_err = 1'b0; v.exp_lat = 3;
    run_req(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrs0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    mem[12'h010] = 8'hF0; mem[12'h011] = 8'h82; mem[12'h012] = 8'h81; mem[12'h013] = 8'h80;
    mem[12'h024] = 8'h44; mem[12'h025] = 8'h33; mem[12'h026] = 8'h22; mem[12'h027] = 8'h11;

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_op", 32'(mem_op), 32'd0);
    chk("rst mem_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0;

    add("LB 010",   1'b0, F3_B,  32'h010, 32'h0, 32'hFFFF_FFF0, 1'b0, 3);
    add("LBU 010",  1'b0, F3_BU, 32'h010, 32'h0, 32'h0000_00F0, 1'b0, 3);
    add("LH 010",   1'b0, F3_H,  32'h010, 32'h0, 32'hFFFF_82F0, 1'b0, 3);
    add("LHU 010",  1'b0, F3_HU, 32'h010, 32'h0, 32'h0000_82F0, 1'b0, 3);
    add("LW 010",   1'b0, F3_W,  32'h010, 32'h0, 32'h8081_82F0, 1'b0, 3);
    add("LB 013",   1'b0, F3_B,  32'h013, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    add("LBU 011",  1'b0, F3_BU, 32'h011, 32'h0, 32'h0000_0082, 1'b0, 3);
    add("SW 020",   1'b1, F3_W,  32'h020, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    add("LW 020a",  1'b0, F3_W,  32'h020, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    add("SB 020",   1'b1, F3_B,  32'h020, 32'h1234_5655, 32'h0, 1'b0, 4);
    add("LW 020b",  1'b0, F3_W,  32'h020, 32'h0, 32'hDEAD_BE55, 1'b0, 3);
    add("LW 024",   1'b0, F3_W,  32'h024, 32'h0, 32'h1122_3344, 1'b0, 3);
    add("SH 022",   1'b1, F3_H,  32'h022, 32'hAAAA_8001, 32'h0, 1'b0, 4);
    add("LH 022",   1'b0, F3_H,  32'h022, 32'h0, 32'hFFFF_8001, 1'b0, 3);
    add("LW 020c",  1'b0, F3_W,  32'h020, 32'h0, 32'h8001_BE55, 1'b0, 3);
    if (TRAP) add("LW 022 mis", 1'b0, F3_W, 32'h022, 32'h0, 32'h0, 1'b1, 1);
    else      add("LW 022 mis", 1'b0, F3_W, 32'h022, 32'h0, 32'h3344_8001, 1'b0, 3);
    add("ld f3=011", 1'b0, 3'b011, 32'h010, 32'h0, 32'h0, TRAP, 1);
    add("st f3=100", 1'b1, 3'b100, 32'h020, 32'hFFFF_FFFF, 32'h0, TRAP, 1);
    add("LW 020d",  1'b0, F3_W,  32'h020, 32'h0, 32'h8001_BE55, 1'b0, 3);
    add("SW wrap",  1'b1, F3_W,  32'h1000_0030, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    add("LW wrap",  1'b0, F3_W,  32'hFFFF_F030, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    if (TRAP) begin
      add("SH 031 mis", 1'b1, F3_H, 32'h031, 32'h0000_BBAA, 32'h0, 1'b1, 1);
      add("LW 030",     1'b0, F3_W, 32'h030, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    end else begin
      add("SH 031 mis", 1'b1, F3_H, 32'h031, 32'h0000_BBAA, 32'h0, 1'b0, 4);
      add("LW 030",     1'b0, F3_W, 32'h030, 32'h0, 32'hCABB_AA0D, 1'b0, 3);
    end

    foreach (vt[i]) run_req(vt[i]);

    // Reset during RWAIT of an SH must abort without writing.
    @(negedge clk);
    wrs0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h020; req_wdata = 32'h0000_FFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abortSH rd mem_op", 32'(mem_op), 32'd1);
    chk("abortSH rd mem_wr", 32'(mem_wr), 32'd0);
    chk("abortSH rd mem_addr", 32'(mem_addr), 32'h020);
    @(negedge clk);
    chk("abortSH rwait mem_op", 32'(mem_op), 32'd0);
    rst = 1'b1;
    #1;
    chk("abortSH ready", 32'(req_ready), 32'd1);
    chk("abortSH resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abortSH writes", 32'(wr_cnt - wrs0), 32'd0);
    load_word("LW after abortSH", 32'h020, 32'h8001_BE55);

    // Reset inside the WR cycle of an SW must suppress the write edge.
    @(negedge clk);
    wrs0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h020; req_wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abortSW wr mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("abortSW mem_wr cleared", 32'(mem_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abortSW writes", 32'(wr_cnt - wrs0), 32'd0);
    load_word("LW after abortSW", 32'h020, 32'h8001_BE55);

    @(negedge clk);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
